// File: rtl/hilbert_pkg.sv
// Shared types and helpers for unpacking fir_hilbert m_axis_data beats
// into packed complex samples.
package hilbert_pkg;

  localparam int DATA_W    = 16;
  localparam int S_TDATA_W = 56;
  localparam int RE_LSB    = 0;
  localparam int IM_LSB    = 32;

  typedef struct packed {
    logic [DATA_W-1:0] im;
    logic [DATA_W-1:0] re;
  } cplx_t;

  // Bit-exact extraction; every bit outside the two fields is ignored.
  function automatic cplx_t unpack(input logic [S_TDATA_W-1:0] tdata,
                                   input int                   im_lsb);
    cplx_t c;
    c.re = tdata[RE_LSB +: DATA_W];
    c.im = tdata[im_lsb +: DATA_W];
    return c;
  endfunction

endpackage

// File: rtl/axis_fwft_fifo.sv
// First-word-fall-through FIFO with a registered output stage. Capacity is
// DEPTH samples counting the one held in the output register.
import hilbert_pkg::*;

module axis_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             pop;
  logic             wr;
  logic             load;

  assign pop       = out_valid & out_ready;
  assign occupancy = mem_cnt + CW'(out_valid);
  assign full      = (occupancy == CW'(DEPTH));
  assign empty     = (occupancy == '0);
  // A full FIFO still accepts when the output register drains this cycle.
  assign wr        = in_valid & (~full | pop);
  // Refill the output register whenever it is free or being consumed.
  assign load      = (~out_valid | pop) & (mem_cnt != '0);

  // NOTE: storage has no reset; pointers and the count define what is valid,
  // so clearing the array would only cost a reset tree for no behaviour.
  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value regardless of order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr)   wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + CW'(wr) - CW'(load);
      if (load) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilbert_cplx_framer.sv
// Buffers fir_hilbert output as {im, re} AXI-Stream beats, frames them with
// tlast every FRAME_LEN beats and accounts for samples lost to overflow.
import hilbert_pkg::*;

module hilbert_cplx_framer #(
  parameter int DATA_W     = hilbert_pkg::DATA_W,
  parameter int S_TDATA_W  = hilbert_pkg::S_TDATA_W,
  parameter int IM_LSB     = hilbert_pkg::IM_LSB,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_axis_data_tvalid,
  input  logic [S_TDATA_W-1:0] s_axis_data_tdata,
  output logic [2*DATA_W-1:0]  m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 overflow,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          frame_cnt
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cplx_t         smp;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_occ;
  logic [BW-1:0] beat_cnt;
  logic          hs;
  logic          drop;

  assign smp = unpack(s_axis_data_tdata, IM_LSB);

  axis_fwft_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (s_axis_data_tvalid),
    .in_data   (smp),
    .out_data  (m_axis_tdata),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // Status taps kept on the FIFO for debug visibility; framing does not need them.
  logic unused_fifo_status;
  assign unused_fifo_status = &{1'b0, fifo_empty, fifo_occ};

  assign hs           = m_axis_tvalid & m_axis_tready;
  assign drop         = s_axis_data_tvalid & fifo_full & ~hs;
  assign m_axis_tlast = (beat_cnt == BW'(FRAME_LEN-1)) & m_axis_tvalid;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (hs) begin
        if (m_axis_tlast) begin
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          beat_cnt  <= beat_cnt + 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
